// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch sequencer between the pipeline front end and the
//               instruction memory port. Owns the fetch PC, issues in-order
//               word requests (req/gnt/rvalid), buffers returned words with
//               their PCs in a small FIFO and presents a valid/ready stream
//               to decode. A redirect flushes the FIFO and discards responses
//               still in flight from the old stream.
// Ports       : clk_i, rst_i (async, active high)
//               mem_req_o, mem_addr_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i
//               redirect_i, redirect_pc_i
//               instr_valid_o, instr_o, instr_pc_o, instr_ready_i
//               misalign_o (one-cycle pulse for a misaligned redirect target)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH);   // FIFO pointer width
  localparam int CW = AW + 1;          // holds 0..DEPTH
  localparam int SW = CW + 1;          // holds 0..2*DEPTH without wrapping

  logic [31:0]   pc_q;
  logic [CW-1:0] out_q;
  // Back-to-back redirects can stack an old drop count on top of a full
  // set of new requests, so the drop counter gets the wider width.
  logic [SW-1:0] drop_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic          misalign_q;

  logic          pop;
  logic          grant;
  logic          resp_keep;
  logic          resp_drop;
  logic [SW-1:0] credit_sum;
  logic [31:0]   push_pc;

  assign instr_valid_o = (count_q != '0) & !redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;

  // Credit check: a new request is allowed only if its response is
  // guaranteed a FIFO slot, counting the slot freed by this cycle's pop.
  assign credit_sum = SW'(count_q) + SW'(out_q) - SW'(pop);
  assign mem_req_o  = !rst_i & !redirect_i & (credit_sum < SW'(DEPTH));
  assign mem_addr_o = pc_q;
  assign grant      = mem_req_o & mem_gnt_i;

  assign resp_keep  = mem_rvalid_i & (drop_q == '0);
  assign resp_drop  = mem_rvalid_i & (drop_q != '0);

  // The oldest kept request was issued out_q words before the current PC.
  assign push_pc    = pc_q - (32'(out_q) << 2);

  assign instr_o    = fifo_instr_q[rd_ptr_q];
  assign instr_pc_o = fifo_pc_q[rd_ptr_q];
  assign misalign_o = misalign_q;

  // PC, outstanding counters and FIFO occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_i & (|redirect_pc_i[1:0]);
      if (redirect_i) begin
        // Everything still owed to the old stream is now garbage; a response
        // landing in this very cycle is part of that garbage.
        pc_q     <= {redirect_pc_i[31:2], 2'b00};
        drop_q   <= drop_q + SW'(out_q) - SW'(mem_rvalid_i);
        out_q    <= '0;
        count_q  <= '0;
        wr_ptr_q <= rd_ptr_q;
      end else begin
        if (grant) begin
          pc_q <= pc_q + 32'd4;
        end
        out_q   <= out_q + CW'(grant) - CW'(resp_keep);
        drop_q  <= drop_q - SW'(resp_drop);
        count_q <= count_q + CW'(resp_keep) - CW'(pop);
        if (resp_keep) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (resp_keep && !redirect_i) begin
      fifo_pc_q[wr_ptr_q]    <= push_pc;
      fifo_instr_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

`ifndef NDEBUG
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (mem_rvalid_i && (out_q == '0) && (drop_q == '0))
        $fatal(1, "fetch_ctrl: response with no request outstanding");
      if (pc_q < BASE_ADDRESS)
        $fatal(1, "fetch_ctrl: fetch PC %h below base address", pc_q);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Randomized self-checking bench for fetch_ctrl. A memory model
//               answers granted requests in order after a chosen latency; a
//               reference model tracks the fetch PC, the queue of requests in
//               flight (each tagged kept or dropped) and the expected
//               instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        misalign;

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (instr_ready),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          keep;
    int          due;
  } req_t;

  req_t        pend[$];     // granted requests not yet answered, oldest first
  logic [31:0] fifo_m[$];   // PCs expected at the decode interface
  logic [31:0] pc_m;
  bit          mis_m;
  int          cyc;
  int          lat;
  int          n_grants;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int kept_cnt();
    int k = 0;
    foreach (pend[i]) if (pend[i].keep) k++;
    return k;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    pend.delete();
    fifo_m.delete();
    pc_m  = RESET_PC;
    mis_m = 0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, then advance
  // the reference model with the same inputs across the rising edge.
  task automatic step(input bit rdy, input bit gnt, input bit rdr, input logic [31:0] rpc);
    bit rv, exp_vld, exp_pop, exp_req;
    req_t r;
    @(negedge clk);
    rv          = (pend.size() > 0) && (pend[0].due <= cyc);
    mem_rvalid  = rv;
    mem_rdata   = rv ? word_at(pend[0].addr) : $urandom;
    mem_gnt     = gnt;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
    exp_vld = (fifo_m.size() != 0) && !rdr;
    exp_pop = exp_vld && rdy;
    exp_req = !rdr && ((fifo_m.size() + kept_cnt() - int'(exp_pop)) < DEPTH);
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("mem_addr", mem_addr, pc_m);
    check("instr_valid", 32'(instr_valid), 32'(exp_vld));
    check("misalign", 32'(misalign), 32'(mis_m));
    if (exp_vld) begin
      check("instr_pc", instr_pc, fifo_m[0]);
      check("instr", instr, word_at(fifo_m[0]));
    end
    @(posedge clk);
    if (rdr) begin
      foreach (pend[i]) pend[i].keep = 0;
      if (rv) void'(pend.pop_front());
      fifo_m.delete();
      pc_m  = {rpc[31:2], 2'b00};
      mis_m = (rpc[1:0] != 2'b00);
    end else begin
      mis_m = 0;
      if (exp_pop) void'(fifo_m.pop_front());
      if (rv) begin
        r = pend.pop_front();
        if (r.keep) fifo_m.push_back(r.addr);
      end
      if (exp_req && gnt) begin
        r.addr = pc_m;
        r.keep = 1;
        r.due  = cyc + lat;
        pend.push_back(r);
        pc_m = pc_m + 32'd4;
        n_grants++;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_addr"}, mem_addr, RESET_PC);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    mem_rvalid = 0;
    mem_gnt    = 0;
    redirect   = 0;
    rst        = 0;
  endtask

  logic [31:0] rpc;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; lat = 1; n_grants = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Streaming with a 1-cycle memory, always granted, always ready
    repeat (20) step(1, 1, 0, '0);

    // Consumer stalled from reset: exactly DEPTH requests, then resume
    rst = 1; model_reset(); mem_rvalid = 0;
    repeat (2) @(posedge clk);
    release_reset();
    n_grants = 0;
    repeat (10) step(0, 1, 0, '0);
    check("stall_grants", n_grants, DEPTH);
    repeat (20) step(1, 1, 0, '0);

    // 3-cycle memory, redirect with responses in flight
    lat = 3;
    repeat (12) step(1, 1, 0, '0);
    step(1, 1, 1, 32'h8000_0100);
    repeat (12) step(1, 1, 0, '0);

    // Misaligned redirect target
    step(1, 1, 1, 32'h8000_0102);
    repeat (6) step(1, 1, 0, '0);

    // Randomized traffic with redirects and varying latency
    for (int blk = 0; blk < 15; blk++) begin
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 100; i++) begin
        rpc = 32'h8000_0000 + 32'($urandom_range(0, 4095));
        step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
             ($urandom_range(0, 99) < 5), rpc);
      end
    end

    // Asynchronous reset mid-stream with a full FIFO
    lat = 1;
    repeat (12) step(0, 1, 0, '0);
    check("fifo_full", fifo_m.size(), DEPTH);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check_reset_outputs("async");
    model_reset();
    mem_rvalid = 0;
    repeat (2) @(posedge clk);
    release_reset();
    repeat (20) step(1, 1, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
